// File: rtl/xercr_file.sv
// XERCR architectural register with a pending-writer scoreboard for CR/XER reads.
// Optional macro XERCR_WB_BYPASS_EN forwards the writeback value to the read port.
`ifndef XERCRSZ
`define XERCRSZ   42
`endif
`ifndef XERCR_CR
`define XERCR_CR  31:0
`endif
`ifndef XERCR_CA
`define XERCR_CA  32
`endif
`ifndef XERCR_OV
`define XERCR_OV  33
`endif
`ifndef XERCR_SO
`define XERCR_SO  34
`endif
`ifndef XERCR_BC
`define XERCR_BC  41:35
`endif

module xercr_file #(
  parameter int PEND_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                claim_valid,
  output logic                claim_ready,
  input  logic                wb_valid,
  input  logic [`XERCRSZ-1:0] wb_xercr,
  input  logic                flush,
  input  logic                rd_sel,
  output logic                rd_ready,
  output logic [31:0]         rd_data,
  input  logic [4:0]          bi,
  output logic                cr_bit,
  output logic [`XERCRSZ-1:0] xercr_out
);

  localparam logic [2:0] PEND_LIM = 3'(PEND_MAX);

  logic [`XERCRSZ-1:0] xercr;
  logic [2:0]          pend;
  logic [2:0]          pend_next;
  logic                claim_acc;
  logic                wb_dec;
  logic [`XERCRSZ-1:0] src;
  logic [31:0]         cr;

  assign claim_ready = (pend < PEND_LIM) || ((pend == PEND_LIM) && wb_valid);
  assign claim_acc   = claim_valid && claim_ready;
  // A writeback with nothing outstanding must not underflow the counter.
  assign wb_dec      = wb_valid && ((pend != 3'd0) || claim_acc);

  always_comb begin
    pend_next = pend;
    if (flush)
      pend_next = 3'd0;
    else if (claim_acc && !wb_dec)
      pend_next = pend + 3'd1;
    else if (wb_dec && !claim_acc)
      pend_next = pend - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xercr <= '0;
      pend  <= 3'd0;
    end else begin
      if (wb_valid)
        xercr <= wb_xercr;
      pend <= pend_next;
    end
  end

`ifdef SIM
  always_ff @(posedge clk) begin
    if (!reset && wb_valid && (pend == 3'd0) && !claim_acc)
      $fatal(1, "XERCR: writeback with no claim");
  end
`endif

`ifdef XERCR_WB_BYPASS_EN
  assign src      = wb_valid ? wb_xercr : xercr;
  assign rd_ready = (pend == 3'd0) || ((pend == 3'd1) && wb_valid && !flush);
`else
  assign src      = xercr;
  assign rd_ready = (pend == 3'd0);
`endif

  assign cr        = src[`XERCR_CR];
  assign rd_data   = rd_sel ? {src[`XERCR_SO], src[`XERCR_OV], src[`XERCR_CA], 22'd0, src[`XERCR_BC]}
                            : cr;
  assign cr_bit    = cr[5'd31 - bi];
  assign xercr_out = xercr;

endmodule

// File: tb/tb_xercr_file.sv
// Directed scoreboard bench for xercr_file: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_xercr_file;

  typedef struct {
    string       name;
    logic [4:0]  care;   // [4] claim_ready [3] rd_ready [2] rd_data [1] cr_bit [0] xercr_out
    logic        claim_ready;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        cr_bit;
    logic [41:0] xercr_out;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        claim_valid = 1'b0;
  logic        claim_ready;
  logic        wb_valid = 1'b0;
  logic [41:0] wb_xercr = '0;
  logic        flush = 1'b0;
  logic        rd_sel = 1'b0;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [4:0]  bi = 5'd0;
  logic        cr_bit;
  logic [41:0] xercr_out;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  xercr_file #(.PEND_MAX(3)) dut (
    .clk(clk), .reset(reset), .claim_valid(claim_valid), .claim_ready(claim_ready),
    .wb_valid(wb_valid), .wb_xercr(wb_xercr), .flush(flush), .rd_sel(rd_sel),
    .rd_ready(rd_ready), .rd_data(rd_data), .bi(bi), .cr_bit(cr_bit), .xercr_out(xercr_out)
  );

  always #5 clk = ~clk;

  // Layout: BC[41:35] SO[34] OV[33] CA[32] CR[31:0]
  function automatic logic [41:0] pack(input logic [6:0] bc, input logic so, ov, ca,
                                       input logic [31:0] crv);
    return {bc, so, ov, ca, crv};
  endfunction

  function automatic exp_t mk(input string n, input logic [4:0] c, input logic cr_e,
                              input logic rr_e, input logic [31:0] rd_e, input logic cb_e,
                              input logic [41:0] xo_e);
    exp_t e;
    e.name = n; e.care = c; e.claim_ready = cr_e; e.rd_ready = rr_e;
    e.rd_data = rd_e; e.cr_bit = cb_e; e.xercr_out = xo_e;
    return e;
  endfunction

  task automatic applyStimulus(input logic rst, cv, wv, input logic [41:0] wx,
                               input logic fl, rs, input logic [4:0] b, input exp_t e);
    @(posedge clk);
    #1;
    reset = rst; claim_valid = cv; wb_valid = wv; wb_xercr = wx;
    flush = fl; rd_sel = rs; bi = b;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    if (e.care[4]) begin
      tests++;
      if (claim_ready !== e.claim_ready) begin
        fails++;
        $display("[TB] FAIL %s claim_ready got %b want %b", e.name, claim_ready, e.claim_ready);
      end
    end
    if (e.care[3]) begin
      tests++;
      if (rd_ready !== e.rd_ready) begin
        fails++;
        $display("[TB] FAIL %s rd_ready got %b want %b", e.name, rd_ready, e.rd_ready);
      end
    end
    if (e.care[2]) begin
      tests++;
      if (rd_data !== e.rd_data) begin
        fails++;
        $display("[TB] FAIL %s rd_data got %h want %h", e.name, rd_data, e.rd_data);
      end
    end
    if (e.care[1]) begin
      tests++;
      if (cr_bit !== e.cr_bit) begin
        fails++;
        $display("[TB] FAIL %s cr_bit got %b want %b", e.name, cr_bit, e.cr_bit);
      end
    end
    if (e.care[0]) begin
      tests++;
      if (xercr_out !== e.xercr_out) begin
        fails++;
        $display("[TB] FAIL %s xercr_out got %h want %h", e.name, xercr_out, e.xercr_out);
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0)
      checkOutput(exp_q.pop_front());
  end

  localparam logic [41:0] V1 = {7'h15, 1'b1, 1'b0, 1'b0, 32'h8000_0000};
  localparam logic [41:0] V2 = {7'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0001};
  localparam logic [41:0] V3 = {7'h7F, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001};
  localparam logic [41:0] V4 = {7'h00, 1'b0, 1'b0, 1'b0, 32'h0000_FFFF};
  localparam logic [41:0] V5 = {7'h00, 1'b0, 1'b0, 1'b0, 32'h1234_5678};
  localparam logic [41:0] Z  = '0;

  initial begin
    int budget;
    if (pack(7'h15, 1'b1, 1'b0, 1'b0, 32'h8000_0000) != V1)
      $display("[TB] note: packing helper disagrees with V1 constant");
    // rst cv wv wx fl rs bi expectation
    applyStimulus(1, 0, 0, Z,  0, 0, 5'd0,  mk("in_reset", 5'b00000, 0, 0, 0, 0, Z));
    applyStimulus(0, 0, 0, Z,  0, 0, 5'd0,  mk("post_reset", 5'b11111, 1, 1, 32'h0, 0, Z));
    applyStimulus(0, 1, 0, Z,  0, 1, 5'd0,  mk("claim1", 5'b11001, 1, 1, 0, 0, Z));
`ifdef XERCR_WB_BYPASS_EN
    applyStimulus(0, 0, 1, V1, 0, 1, 5'd0,  mk("wb_bypass", 5'b11111, 1, 1, 32'h8000_0015, 1, Z));
`else
    applyStimulus(0, 0, 1, V1, 0, 1, 5'd0,  mk("wb_nobypass", 5'b11001, 1, 0, 0, 0, Z));
`endif
    applyStimulus(0, 0, 0, Z,  0, 1, 5'd0,  mk("xer_view", 5'b11111, 1, 1, 32'h8000_0015, 1, V1));
    applyStimulus(0, 0, 0, Z,  0, 0, 5'd1,  mk("cr_view_bi1", 5'b01111, 0, 1, 32'h8000_0000, 0, V1));
    // Fill to the claim limit, then a claim paired with writeback is accepted at the limit.
    applyStimulus(0, 1, 0, Z,  0, 0, 5'd0,  mk("fill1", 5'b11000, 1, 1, 0, 0, Z));
    applyStimulus(0, 1, 0, Z,  0, 0, 5'd0,  mk("fill2", 5'b11000, 1, 0, 0, 0, Z));
    applyStimulus(0, 1, 0, Z,  0, 0, 5'd0,  mk("fill3", 5'b11000, 1, 0, 0, 0, Z));
    applyStimulus(0, 1, 0, Z,  0, 0, 5'd0,  mk("full_block", 5'b11001, 0, 0, 0, 0, V1));
    applyStimulus(0, 1, 1, V2, 0, 0, 5'd0,  mk("full_claim_wb", 5'b11001, 1, 0, 0, 0, V1));
    applyStimulus(0, 0, 0, Z,  0, 0, 5'd0,  mk("still_full", 5'b11001, 0, 0, 0, 0, V2));
    applyStimulus(0, 0, 1, V2, 0, 0, 5'd0,  mk("drain3", 5'b11000, 1, 0, 0, 0, Z));
    applyStimulus(0, 0, 1, V2, 0, 0, 5'd0,  mk("drain2", 5'b11000, 1, 0, 0, 0, Z));
`ifdef XERCR_WB_BYPASS_EN
    applyStimulus(0, 0, 1, V3, 0, 1, 5'd31, mk("drain1_bp", 5'b11111, 1, 1, 32'h6000_007F, 1, V2));
`else
    applyStimulus(0, 0, 1, V3, 0, 1, 5'd31, mk("drain1", 5'b11001, 1, 0, 0, 0, V2));
`endif
    applyStimulus(0, 0, 0, Z,  0, 1, 5'd31, mk("xer_ovca", 5'b11111, 1, 1, 32'h6000_007F, 1, V3));
    // Claim and writeback together keep one writer outstanding.
    applyStimulus(0, 1, 0, Z,  0, 0, 5'd0,  mk("claim_a", 5'b01000, 0, 1, 0, 0, Z));
    applyStimulus(0, 1, 1, V4, 0, 0, 5'd0,  mk("claim_wb", 5'b10001, 1, 0, 0, 0, V3));
    applyStimulus(0, 0, 0, Z,  0, 0, 5'd0,  mk("pend_stays1", 5'b11001, 1, 0, 0, 0, V4));
    // Flush with writeback: counter clears, data still lands.
    applyStimulus(0, 1, 0, Z,  0, 0, 5'd0,  mk("claim_b", 5'b01000, 0, 0, 0, 0, Z));
    applyStimulus(0, 0, 1, V5, 1, 0, 5'd3,  mk("flush_wb", 5'b01000, 0, 0, 0, 0, Z));
    applyStimulus(0, 0, 0, Z,  0, 0, 5'd3,  mk("after_flush", 5'b11111, 1, 1, 32'h1234_5678, 1, V5));
    applyStimulus(0, 1, 0, Z,  1, 0, 5'd0,  mk("claim_flush", 5'b11000, 1, 1, 0, 0, Z));
    applyStimulus(0, 0, 0, Z,  0, 0, 5'd0,  mk("claim_dropped", 5'b01000, 0, 1, 0, 0, Z));
    // Reset discards outstanding writers and overrides a simultaneous claim.
    applyStimulus(0, 1, 0, Z,  0, 0, 5'd0,  mk("claim_c", 5'b00000, 0, 0, 0, 0, Z));
    applyStimulus(0, 1, 0, Z,  0, 0, 5'd0,  mk("claim_d", 5'b01000, 0, 0, 0, 0, Z));
    applyStimulus(1, 1, 0, Z,  0, 0, 5'd0,  mk("reset_mid", 5'b00000, 0, 0, 0, 0, Z));
    applyStimulus(0, 0, 0, Z,  0, 0, 5'd0,  mk("after_reset", 5'b11111, 1, 1, 32'h0, 0, Z));
    applyStimulus(0, 0, 1, V1, 0, 0, 5'd0,  mk("stray_wb", 5'b11000, 1, 1, 0, 0, Z));
    applyStimulus(0, 0, 0, Z,  0, 0, 5'd0,  mk("no_underflow", 5'b11101, 1, 1, 32'h8000_0000, 0, V1));
    applyStimulus(0, 0, 0, Z,  0, 0, 5'd0,  mk("idle_end", 5'b00000, 0, 0, 0, 0, Z));

    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain queue left %0d required 0", exp_q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xercr_file.md
XERCR_FILE -- requirements
Module: xercr_file

Interface
REQ-001 SHALL have parameter PEND_MAX, default 3, meaning the maximum number of in-flight XERCR writers tracked (1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port claim_valid, input, 1, meaning decode issues an instruction whose exe_rc_op writes XERCR.
REQ-005 SHALL have port claim_ready, output, 1, meaning a claim is accepted this cycle.
REQ-006 SHALL have port wb_valid, input, 1, meaning writeback presents a new combined XERCR value.
REQ-007 SHALL have port wb_xercr, input, `XERCRSZ, the new XERCR value produced by execute.
REQ-008 SHALL have port flush, input, 1, meaning all claimed-but-not-written instructions are squashed.
REQ-009 SHALL have port rd_sel, input, 1, selecting the mfcr/mfxer view: 0 = CR, 1 = XER.
REQ-010 SHALL have port rd_ready, output, 1, meaning rd_data and cr_bit reflect all older writers.
REQ-011 SHALL have port rd_data, output, 32, the formatted CR or XER value.
REQ-012 SHALL have port bi, input, 5, the branch condition bit index (0 = CR bit 31).
REQ-013 SHALL have port cr_bit, output, 1, the CR bit selected by bi.
REQ-014 SHALL have port xercr_out, output, `XERCRSZ, the architectural XERCR fed to the execute rc_in port.

Function
REQ-015 SHALL hold the architectural XERCR register xercr, loaded with wb_xercr on any cycle where wb_valid=1; the new value is visible on xercr_out the following cycle.
REQ-016 SHALL hold a pending counter pend, 3 bits wide, counting claimed-but-not-written instructions.
REQ-017 SHALL drive claim_ready=1 when pend<PEND_MAX, or when pend==PEND_MAX and wb_valid=1 in the same cycle.
REQ-018 SHALL update pend per cycle as follows: an accepted claim only increments it; wb_valid only decrements it; both together leave it unchanged.
REQ-019 SHALL ignore wb_valid for pend when pend==0 and no claim is accepted; xercr still loads. Under SIM this SHALL raise $fatal "XERCR: writeback with no claim".
REQ-020 SHALL set pend to 0 on flush, overriding claim and wb for the counter; a simultaneous wb_valid still loads xercr, and a simultaneous claim is dropped.
REQ-021 SHALL drive rd_ready=1 iff pend==0, subject to REQ-033.
REQ-022 SHALL, for rd_sel=0, drive rd_data equal to the CR field, xercr bits 31:0.
REQ-023 SHALL, for rd_sel=1, drive rd_data bit31=`XERCR_SO, bit30=`XERCR_OV, bit29=`XERCR_CA, bits28:7=0, and bits6:0=`XERCR_BC.
REQ-024 SHALL drive cr_bit equal to CR bit (31-bi).
REQ-025 SHALL compute rd_data and cr_bit combinationally from the selected XERCR source with no added latency; they are meaningful only when rd_ready=1.
REQ-026 SHALL drive xercr_out directly from the xercr register, never bypassed, so execute sees no combinational path from wb.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, set xercr to 0 and pend to 0, overriding claim, wb and flush.
REQ-028 SHALL present these outputs the cycle after reset: claim_ready=1, rd_ready=1, rd_data=0, cr_bit=0, xercr_out=0.
REQ-029 SHALL discard a writer in flight when reset is asserted; its later wb_valid is treated per REQ-019.

Configuration
REQ-030 SHALL provide the macro XERCR_WB_BYPASS_EN.
REQ-031 SHALL, without XERCR_WB_BYPASS_EN, take rd_data and cr_bit from the xercr register only, with rd_ready per REQ-021.
REQ-032 SHALL, with XERCR_WB_BYPASS_EN and wb_valid=1, take rd_data and cr_bit from wb_xercr instead.
REQ-033 SHALL, with XERCR_WB_BYPASS_EN, also drive rd_ready=1 when pend==1 and wb_valid=1 and flush=0, saving one cycle on reads such as mfcr after a record-form instruction.

Verification
REQ-034 SHALL be verified by: reset, then wb_valid with wb_xercr CR=0x80000000 and SO=1, BC=0x15, then rd_sel=1 -> rd_data=0x80000015; with rd_sel=0 -> rd_data=0x80000000; with bi=0 -> cr_bit=1.
REQ-035 SHALL be verified by: 3 claims with PEND_MAX=3, then a 4th claim -> claim_ready=0, pend=3; the 4th claim repeated with wb_valid in the same cycle -> accepted, pend stays 3.
REQ-036 SHALL be verified by: claim then read -> rd_ready=0 until the wb cycle; with bypass, rd_ready=1 in the wb cycle with rd_data=new CR; without bypass, rd_ready=1 and new data one cycle later.
REQ-037 SHALL be verified by: 2 claims, then flush together with wb_valid (CR=0x12345678) -> pend=0, rd_ready=1 next cycle, rd_data=0x12345678.
REQ-038 SHALL be verified by: 2 claims, then reset -> pend=0, xercr_out=0, claim_ready=1; a subsequent wb_valid -> SIM fatal.
REQ-039 SHALL be verified by: claim and wb_valid in the same cycle with pend=1 -> pend stays 1, xercr updated next cycle, rd_ready stays 0.
